// File: rtl/j1_loader_pkg.sv
// j1_loader_pkg: shared definitions for the j1 boot loader.
//   - state encoding of the frame-receive FSM
//   - sticky error codes reported on the err port
//   - frame byte order (length and data words travel low byte first)
package j1_loader_pkg;

    localparam logic [2:0] ENC_LEN_LO  = 3'd0;
    localparam logic [2:0] ENC_LEN_HI  = 3'd1;
    localparam logic [2:0] ENC_DATA_LO = 3'd2;
    localparam logic [2:0] ENC_DATA_HI = 3'd3;
    localparam logic [2:0] ENC_CSUM    = 3'd4;
    localparam logic [2:0] ENC_RUN     = 3'd5;
    localparam logic [2:0] ENC_ERROR   = 3'd6;

    typedef enum logic [2:0] {
        ST_LEN_LO  = ENC_LEN_LO,
        ST_LEN_HI  = ENC_LEN_HI,
        ST_DATA_LO = ENC_DATA_LO,
        ST_DATA_HI = ENC_DATA_HI,
        ST_CSUM    = ENC_CSUM,
        ST_RUN     = ENC_RUN,
        ST_ERROR   = ENC_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_LEN     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // Multi-byte fields are little-endian: the first byte received is the LSB.
    function automatic logic [15:0] frame_word(input logic [7:0] first_byte,
                                               input logic [7:0] second_byte);
        return {second_byte, first_byte};
    endfunction

endpackage

// File: rtl/j1_loader_csum.sv
// j1_loader_csum: 8-bit wrap-around frame checksum accumulator.
// Ports:
//   i_clk, i_reset  - clock, synchronous active-high reset
//   i_clear         - restart the sum (with i_data if i_add is also set, else 0)
//   i_add           - add i_data into the running sum
//   i_data          - byte being accepted
//   o_is_zero       - the sum including the byte presented on i_data is 0x00
module j1_loader_csum (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clear,
    input  logic       i_add,
    input  logic [7:0] i_data,
    output logic       o_is_zero
);

    logic [7:0] r_sum;
    logic [7:0] w_sum_next;

    assign w_sum_next = r_sum + i_data;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sum <= 8'h00;
        end else if (i_clear) begin
            r_sum <= i_add ? i_data : 8'h00;
        end else if (i_add) begin
            r_sum <= w_sum_next;
        end
    end

    // Looks through the byte on i_data so the checksum byte can be judged
    // in the same cycle it is accepted.
    assign o_is_zero = (w_sum_next == 8'h00);

endmodule

// File: rtl/j1_loader.sv
// j1_loader: boot sequencer for the j1 core. Holds the core in reset, takes a
// framed image {LEN lo, LEN hi, N x (data lo, data hi), CSUM} from a byte
// stream, writes it to code RAM and releases the core on a good checksum.
// Optional build macro: J1_LOADER_TIMEOUT_EN adds an inter-byte timeout.
// Ports:
//   i_clk, i_reset              - clock, synchronous active-high reset
//   i_rx_data, i_rx_valid       - incoming byte stream
//   o_rx_ready                  - byte accepted when i_rx_valid & o_rx_ready
//   i_reload                    - return to reset and re-arm (RUN only)
//   o_code_we/waddr/wdata       - code RAM write port, one strobe per word
//   o_core_resetq               - active-low reset to the j1 core
//   o_busy, o_load_done, o_err  - status
//
// state      | meaning
// -----------+--------------------------------------------------------
// LEN_LO     | idle, waiting for length low byte
// LEN_HI     | waiting for length high byte, range check on accept
// DATA_LO    | waiting for word low byte
// DATA_HI    | waiting for word high byte, write issued next cycle
// CSUM       | waiting for checksum byte
// RUN        | core released, input stalled, waiting for reload
// ERROR      | bad frame; next byte is a new length low byte
module j1_loader
    import j1_loader_pkg::*;
#(
    parameter int CODE_AW = 13
`ifdef J1_LOADER_TIMEOUT_EN
    , parameter int TIMEOUT = 100000
`endif
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_rx_ready,
    input  logic               i_reload,
    output logic               o_code_we,
    output logic [CODE_AW-1:0] o_code_waddr,
    output logic [15:0]        o_code_wdata,
    output logic               o_core_resetq,
    output logic               o_busy,
    output logic               o_load_done,
    output logic [1:0]         o_err
);

    localparam logic [16:0] LEN_CAP = 17'(2 ** CODE_AW);

    state_t             r_state;
    state_t             w_state_next;
    logic               w_hs;
    logic [15:0]        w_len;
    logic               w_len_over;
    logic               w_len_zero;
    logic               w_last_word;
    logic               w_csum_zero;
    logic               w_sum_clear;
    logic               w_timeout;
    logic               w_err_set;
    logic [1:0]         w_err_code;
    logic               w_load_good;

    logic [7:0]         r_len_lo;
    logic [CODE_AW-1:0] r_len_m1;
    logic [CODE_AW-1:0] r_widx;
    logic [7:0]         r_lo;
    logic               r_we;
    logic [CODE_AW-1:0] r_waddr;
    logic [15:0]        r_wdata;
    logic               r_core_resetq;
    logic               r_load_done;
    logic [1:0]         r_err;

    assign o_rx_ready  = (r_state != ST_RUN);
    assign w_hs        = i_rx_valid & o_rx_ready;
    assign w_len       = frame_word(r_len_lo, i_rx_data);
    assign w_len_over  = ({1'b0, w_len} > LEN_CAP);
    assign w_len_zero  = (w_len == 16'h0000);
    assign w_last_word = (r_widx == r_len_m1);

    // LEN_LO and ERROR start a fresh sum with the accepted byte; RUN and a
    // timeout leave it at zero for the next frame.
    assign w_sum_clear = (r_state == ST_LEN_LO) || (r_state == ST_ERROR) ||
                         (r_state == ST_RUN) || w_timeout;

    j1_loader_csum u_csum (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (w_sum_clear),
        .i_add     (w_hs),
        .i_data    (i_rx_data),
        .o_is_zero (w_csum_zero)
    );

`ifdef J1_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] r_idle;
    logic            w_timed;

    assign w_timed = (r_state == ST_LEN_HI) || (r_state == ST_DATA_LO) ||
                     (r_state == ST_DATA_HI) || (r_state == ST_CSUM);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_idle <= TO_W'(TIMEOUT - 1);
        end else if (!w_timed || w_hs || w_timeout) begin
            r_idle <= TO_W'(TIMEOUT - 1);
        end else begin
            r_idle <= r_idle - 1'b1;
        end
    end

    assign w_timeout = w_timed && !w_hs && (r_idle == '0);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_LEN_LO;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_err_set    = 1'b0;
        w_err_code   = ERR_NONE;
        w_load_good  = 1'b0;
        if (w_timeout) begin
            w_state_next = ST_LEN_LO;
            w_err_set    = 1'b1;
            w_err_code   = ERR_TIMEOUT;
        end else begin
            case (r_state)
                ST_LEN_LO: if (w_hs) w_state_next = ST_LEN_HI;
                ST_LEN_HI: begin
                    if (w_hs) begin
                        if (w_len_over) begin
                            w_state_next = ST_ERROR;
                            w_err_set    = 1'b1;
                            w_err_code   = ERR_LEN;
                        end else if (w_len_zero) begin
                            w_state_next = ST_CSUM;
                        end else begin
                            w_state_next = ST_DATA_LO;
                        end
                    end
                end
                ST_DATA_LO: if (w_hs) w_state_next = ST_DATA_HI;
                ST_DATA_HI: if (w_hs) w_state_next = w_last_word ? ST_CSUM : ST_DATA_LO;
                ST_CSUM: begin
                    if (w_hs) begin
                        if (w_csum_zero) begin
                            w_state_next = ST_RUN;
                            w_load_good  = 1'b1;
                        end else begin
                            w_state_next = ST_ERROR;
                            w_err_set    = 1'b1;
                            w_err_code   = ERR_CSUM;
                        end
                    end
                end
                ST_RUN:   if (i_reload) w_state_next = ST_LEN_LO;
                ST_ERROR: if (w_hs) w_state_next = ST_LEN_HI;
                default:  w_state_next = ST_LEN_LO;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_len_lo      <= 8'h00;
            r_len_m1      <= '0;
            r_widx        <= '0;
            r_lo          <= 8'h00;
            r_we          <= 1'b0;
            r_waddr       <= '0;
            r_wdata       <= 16'h0000;
            r_core_resetq <= 1'b0;
            r_load_done   <= 1'b0;
            r_err         <= ERR_NONE;
        end else begin
            r_we          <= 1'b0;
            r_load_done   <= w_load_good;
            r_core_resetq <= (w_state_next == ST_RUN);
            if (w_err_set) begin
                r_err <= w_err_code;
            end else if (w_load_good) begin
                r_err <= ERR_NONE;
            end
            if (w_hs && !w_timeout) begin
                case (r_state)
                    ST_LEN_LO, ST_ERROR: r_len_lo <= i_rx_data;
                    ST_LEN_HI: begin
                        r_len_m1 <= CODE_AW'(w_len - 16'd1);
                        r_widx   <= '0;
                    end
                    ST_DATA_LO: r_lo <= i_rx_data;
                    ST_DATA_HI: begin
                        r_we    <= 1'b1;
                        r_waddr <= r_widx;
                        r_wdata <= frame_word(r_lo, i_rx_data);
                        // Hold at the last index so a full image never wraps to 0.
                        if (!w_last_word) begin
                            r_widx <= r_widx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_code_we     = r_we;
    assign o_code_waddr  = r_waddr;
    assign o_code_wdata  = r_wdata;
    assign o_core_resetq = r_core_resetq;
    assign o_busy        = (r_state != ST_LEN_LO) && (r_state != ST_RUN) &&
                           (r_state != ST_ERROR);
    assign o_load_done   = r_load_done;
    assign o_err         = r_err;

endmodule
